stack_cmd_ctrl: RTL and testbench
=================================

# stack_cmd_ctrl

Command sequencer that sits directly upstream of the dual-stack storage block. It accepts one command per valid/ready handshake from the host-side pin interface and drives that block's `push`, `pop`, `stack_select` and `data_in` strobes. It checks each command against the per-stack full/empty flags, captures popped words from the stack read port, and returns a one-cycle response with result data and an error bit. Multi-step operations (move, dup) are sequenced here so the storage block only ever sees single push or pop strobes.

## Interface
- `POP_LAT`, default 1: cycles from a `pop` strobe to valid popped data on `stk_data`; legal range 0–3.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command; high only in IDLE.
- `cmd_op` in 3: opcode, one of:
  - 0 NOP
  - 1 PUSH
  - 2 POP
  - 3 MOVE
  - 4 DUP
  - 5 STATUS
  - 6–7 illegal
- `cmd_sel` in 1: target stack (0/1).
- `cmd_data` in 8: push operand.
- `rsp_valid` out 1: single-cycle response pulse; no backpressure.
- `rsp_data` out 8: response payload.
- `rsp_err` out 1: command rejected; qualified by `rsp_valid`.
- `stack_select` out 1: to storage, selects the stack for this strobe.
- `push` out 1: to storage, push strobe.
- `pop` out 1: to storage, pop strobe.
- `data_in` out 8: to storage, push data.
- `stk_data` in 8: from storage `data_out`.
- `s0_empty`, `s0_full`, `s1_empty`, `s1_full` in 1 each: storage flags.

## Operation
- **Handshake and latching**
  - Accept on `cmd_valid && cmd_ready` at the edge ending cycle C.
  - `cmd_op`, `cmd_sel` and `cmd_data` are latched at that edge.
  - Input values outside an accepting cycle are ignored.
- **States:** IDLE, EXEC, POP_WAIT, PUSH_A, PUSH_B.
  - IDLE → EXEC on accept.
  - Every path returns to IDLE in the cycle after `rsp_valid`.
- **EXEC (cycle C+1):** the flags are evaluated combinationally this cycle. Let "sel" be the latched stack and "oth" the other stack.
  - NOP: `rsp_valid`=1, `rsp_data`=0x00, `rsp_err`=0.
  - STATUS: `rsp_data`={4'b0, s1_full, s1_empty, s0_full, s0_empty}, `rsp_err`=0.
  - PUSH:
    - If sel full: error.
    - Else `push`=1, `stack_select`=sel, `data_in`=cmd_data. Respond the same cycle with `rsp_data`=cmd_data.
  - POP:
    - If sel empty: error.
    - Else `pop`=1, `stack_select`=sel. Go to POP_WAIT.
  - MOVE:
    - If sel empty or oth full: error.
    - Else `pop` sel. Go to POP_WAIT.
  - DUP:
    - If sel empty or sel full: error.
    - Else `pop` sel. Go to POP_WAIT.
  - Illegal op: error.
- **Error response:** `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0x00. No stack strobe is issued and stack contents are unchanged.
- **POP_WAIT:** counts POP_LAT cycles (0 means same cycle as EXEC), then captures `stk_data` into a hold register. The capture cycle is C+1+POP_LAT.
  - POP: respond in the capture cycle with `rsp_data`=stk_data.
  - MOVE: go to PUSH_A on the other stack.
  - DUP: go to PUSH_A on the same stack.
- **PUSH_A:** `push`=1, `data_in`=held word.
  - MOVE: `stack_select`=oth; respond with `rsp_data`=held word.
  - DUP: `stack_select`=sel; go to PUSH_B.
- **PUSH_B (DUP only):** `push`=1, `stack_select`=sel, `data_in`=held word; respond with `rsp_data`=held word.
- **Strobe rules**
  - `push` and `pop` are never high in the same cycle.
  - Each strobe is high exactly one cycle per step.
  - `stack_select` is 0 whenever neither strobe is high.
- **Flag checking:** flags are checked only in EXEC. A DUP passes the check with depth ≤ capacity−1, so the net +1 depth cannot overflow.

## Timing
- **Reset values** (cycle in which `rst_n`=0 is sampled, and the following cycle):
  - state=IDLE.
  - `push`, `pop`, `stack_select`, `rsp_valid`, `rsp_err`=0.
  - `rsp_data`, `data_in`=0x00.
- **`cmd_ready` around reset:** 0 while `rst_n`=0; 1 in the first cycle after `rst_n` returns high.
- **Reset mid-operation:** aborts the sequence. No further strobe or response is issued and the held word is discarded. Storage is reset by the same `rst_n`.
- **Latency**, from accept cycle C to `rsp_valid`:
  - NOP, STATUS, PUSH, any error: C+1.
  - POP: C+1+POP_LAT.
  - MOVE: C+2+POP_LAT.
  - DUP: C+3+POP_LAT.
- **Throughput:** `cmd_ready` reasserts the cycle after `rsp_valid`, so the best case is one command every 2 cycles.
- **Output timing:** `rsp_valid` is a one-cycle pulse. `rsp_data` and `rsp_err` hold their value until the next response.

## Test plan
- Reset, then PUSH s0 0xA5 and POP s0 (POP_LAT=1):
  - `push` at C+1 with `data_in`=0xA5.
  - POP pops at its C+1 and returns `rsp_data`=0xA5 at C+2, `rsp_err`=0.
- POP s1 on an empty stack → `rsp_err`=1, `rsp_data`=0x00 at C+1, no `pop` strobe. Then PUSH s0 until `s0_full` and push once more → error, no `push` strobe.
- PUSH s0 0x3C, then MOVE sel=0:
  - `pop` s0 at C+1, `push` s1 with 0x3C at C+3, `rsp_data`=0x3C.
  - POP s1 then returns 0x3C and s0 is empty.
- PUSH s1 0x77, then DUP s1:
  - `pop` s1 at C+1, then two `push` s1 of 0x77 at C+3 and C+4, response at C+4.
  - Two POPs each return 0x77.
- STATUS after reset → `rsp_data`=0x05. Opcode 7 → `rsp_err`=1. Back-to-back `cmd_valid`: `cmd_ready` is low in every non-IDLE cycle.
- Assert `rst_n`=0 during POP_WAIT of a MOVE → no `push`, no `rsp_valid`. `cmd_ready`=1 in the cycle after reset is released.

Source files
------------

// File: rtl/stack_cmd_ctrl.sv
// rtl/stack_cmd_ctrl.sv - command sequencer in front of a dual-stack storage block
// Turns host commands into single push/pop strobes and returns one response per command.
module stack_cmd_ctrl #(
  parameter int POP_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_sel,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       stack_select,
  output logic       push,
  output logic       pop,
  output logic [7:0] data_in,
  input  logic [7:0] stk_data,
  input  logic       s0_empty,
  input  logic       s0_full,
  input  logic       s1_empty,
  input  logic       s1_full
);

  typedef enum logic [2:0] {IDLE, EXEC, POP_WAIT, PUSH_A, PUSH_B} state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_PUSH   = 3'd1;
  localparam logic [2:0] OP_POP    = 3'd2;
  localparam logic [2:0] OP_MOVE   = 3'd3;
  localparam logic [2:0] OP_DUP    = 3'd4;
  localparam logic [2:0] OP_STATUS = 3'd5;
  localparam logic [1:0] LAT       = 2'(POP_LAT);

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic       sel_q;
  logic [7:0] data_q;
  logic [7:0] hold_q, hold_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;

  logic       rv, re, psh, pp, ss, reject, capture;
  logic [7:0] rd, din;
  logic       sel_empty, sel_full, oth_full;

  assign sel_empty = sel_q ? s1_empty : s0_empty;
  assign sel_full  = sel_q ? s1_full  : s0_full;
  assign oth_full  = sel_q ? s0_full  : s1_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv      = 1'b0;
    re      = 1'b0;
    rd      = 8'h00;
    psh     = 1'b0;
    pp      = 1'b0;
    ss      = 1'b0;
    din     = 8'h00;
    reject  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_NOP:    ;
          OP_STATUS: rd = {4'b0000, s1_full, s1_empty, s0_full, s0_empty};
          OP_PUSH:   reject = sel_full;
          OP_POP:    reject = sel_empty;
          OP_MOVE:   reject = sel_empty | oth_full;
          OP_DUP:    reject = sel_empty | sel_full;
          default:   reject = 1'b1;
        endcase
        if (reject) begin
          rv      = 1'b1;
          re      = 1'b1;
          rd      = 8'h00;
          state_d = IDLE;
        end else if (op_q == OP_POP || op_q == OP_MOVE || op_q == OP_DUP) begin
          pp = 1'b1;
          ss = sel_q;
          // With zero pop latency the word is already on stk_data in this cycle.
          if (POP_LAT == 0) begin
            capture = 1'b1;
          end else begin
            state_d = POP_WAIT;
            cnt_d   = 2'd1;
          end
        end else begin
          rv      = 1'b1;
          state_d = IDLE;
          if (op_q == OP_PUSH) begin
            psh = 1'b1;
            ss  = sel_q;
            din = data_q;
            rd  = data_q;
          end
        end
      end
      POP_WAIT: begin
        if (cnt_q == LAT) capture = 1'b1;
        else              cnt_d = cnt_q + 2'd1;
      end
      PUSH_A: begin
        psh = 1'b1;
        din = hold_q;
        if (op_q == OP_MOVE) begin
          ss      = ~sel_q;
          rv      = 1'b1;
          rd      = hold_q;
          state_d = IDLE;
        end else begin
          ss      = sel_q;
          state_d = PUSH_B;
        end
      end
      PUSH_B: begin
        psh     = 1'b1;
        ss      = sel_q;
        din     = hold_q;
        rv      = 1'b1;
        rd      = hold_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      if (op_q == OP_POP) begin
        rv      = 1'b1;
        rd      = stk_data;
        state_d = IDLE;
      end else begin
        state_d = PUSH_A;
      end
    end
    hold_d = capture ? stk_data : hold_q;
  end

  // Gating with rst_n keeps a sequence that is being reset from issuing anything.
  assign cmd_ready    = rst_n & (state_q == IDLE);
  assign rsp_valid    = rst_n & rv;
  assign push         = rst_n & psh;
  assign pop          = rst_n & pp;
  assign stack_select = rst_n & ss;
  assign data_in      = rst_n ? din : 8'h00;
  assign rsp_data     = !rst_n ? 8'h00 : (rv ? rd : rsp_data_q);
  assign rsp_err      = rst_n & (rv ? re : rsp_err_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      sel_q      <= 1'b0;
      data_q     <= 8'h00;
      hold_q     <= 8'h00;
      cnt_q      <= 2'd0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      if (state_q == IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        sel_q  <= cmd_sel;
        data_q <= cmd_data;
      end
      if (rv) begin
        rsp_data_q <= rd;
        rsp_err_q  <= re;
      end
    end
  end

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// tb/tb_stack_cmd_ctrl.sv - scoreboard bench for stack_cmd_ctrl with a behavioural dual-stack storage
module tb_stack_cmd_ctrl;
  localparam int L    = 1;
  localparam int CAP  = 4;
  localparam int LOGN = 2048;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_sel;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_data;
  logic       stack_select, push, pop;
  logic [7:0] data_in, stk_data;
  logic       s0_empty, s0_full, s1_empty, s1_full;

  stack_cmd_ctrl #(.POP_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stack_select(stack_select), .push(push), .pop(pop), .data_in(data_in),
    .stk_data(stk_data), .s0_empty(s0_empty), .s0_full(s0_full),
    .s1_empty(s1_empty), .s1_full(s1_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural storage: registered read port, one cycle pop latency
  logic [7:0] mem0 [8];
  logic [7:0] mem1 [8];
  logic [2:0] d0, d1;
  assign s0_empty = (d0 == 3'd0);
  assign s0_full  = (d0 == 3'(CAP));
  assign s1_empty = (d1 == 3'd0);
  assign s1_full  = (d1 == 3'(CAP));

  always @(posedge clk) begin
    if (!rst_n) begin
      d0 <= 3'd0; d1 <= 3'd0; stk_data <= 8'h00;
    end else begin
      if (push && !stack_select && d0 < 3'(CAP)) begin mem0[d0] <= data_in; d0 <= d0 + 3'd1; end
      if (push &&  stack_select && d1 < 3'(CAP)) begin mem1[d1] <= data_in; d1 <= d1 + 3'd1; end
      if (pop  && !stack_select && d0 > 3'd0) begin stk_data <= mem0[d0 - 3'd1]; d0 <= d0 - 3'd1; end
      if (pop  &&  stack_select && d1 > 3'd0) begin stk_data <= mem1[d1 - 3'd1]; d1 <= d1 - 3'd1; end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         lat;
    int         acc;
  } exp_t;
  exp_t sb[$];
  logic [7:0] ref0[$];
  logic [7:0] ref1[$];
  bit inflight = 0;

  logic       push_log [LOGN];
  logic       pop_log  [LOGN];
  logic       sel_log  [LOGN];
  logic [7:0] din_log  [LOGN];

  always @(negedge clk) begin
    exp_t e;
    if (cyc < LOGN) begin
      push_log[cyc] = push; pop_log[cyc] = pop; sel_log[cyc] = stack_select; din_log[cyc] = data_in;
    end
    if (!rst_n) inflight = 0;
    check("strobe_excl", {31'd0, push & pop}, 0);
    if (!push && !pop) check("sel_idle", {31'd0, stack_select}, 0);
    if (inflight) check("ready_busy", {31'd0, cmd_ready}, 0);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexp", {31'd0, rsp_valid}, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", {24'd0, rsp_data}, {24'd0, e.d});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
        check("rsp_lat", cyc - e.acc, e.lat);
        inflight = 0;
      end
    end
  end

  function automatic int depth(input logic s);
    return s ? ref1.size() : ref0.size();
  endfunction

  task automatic ref_push(input logic s, input logic [7:0] v);
    if (s) ref1.push_back(v); else ref0.push_back(v);
  endtask

  function automatic logic [7:0] ref_pop(input logic s);
    if (s) return ref1.pop_back();
    return ref0.pop_back();
  endfunction

  task automatic predict(input logic [2:0] op, input logic s, input logic [7:0] d,
                         output logic [7:0] ed, output logic ee, output int lat);
    ed = 8'h00; ee = 1'b0; lat = 1;
    case (op)
      3'd0: ;
      3'd5: ed = {4'b0, depth(1) == CAP, depth(1) == 0, depth(0) == CAP, depth(0) == 0};
      3'd1: if (depth(s) == CAP) ee = 1'b1; else begin ref_push(s, d); ed = d; end
      3'd2: if (depth(s) == 0) ee = 1'b1; else begin ed = ref_pop(s); lat = 1 + L; end
      3'd3: if (depth(s) == 0 || depth(!s) == CAP) ee = 1'b1;
            else begin ed = ref_pop(s); ref_push(!s, ed); lat = 2 + L; end
      3'd4: if (depth(s) == 0 || depth(s) == CAP) ee = 1'b1;
            else begin ed = ref_pop(s); ref_push(s, ed); ref_push(s, ed); lat = 3 + L; end
      default: ee = 1'b1;
    endcase
  endtask

  task automatic send(input logic [2:0] op, input logic s, input logic [7:0] d,
                      input bit want_rsp, output int acc);
    exp_t e;
    int n = 0;
    acc = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("ready_timeout", {31'd0, cmd_ready}, 1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = s; cmd_data = d;
    @(posedge clk);
    #1;
    acc = cyc - 1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_sel = 1'($urandom); cmd_data = 8'($urandom);
    if (want_rsp) begin
      predict(op, s, d, e.d, e.e, e.lat);
      e.acc = acc;
      sb.push_back(e);
    end
    inflight = 1;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || inflight) && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0 || inflight) check("rsp_timeout", sb.size(), 0);
  endtask

  task automatic chk_strb(input string tag, input int k, input logic p, input logic q,
                          input logic s, input logic [7:0] din);
    check({tag, "_push"}, {31'd0, push_log[k]}, {31'd0, p});
    check({tag, "_pop"},  {31'd0, pop_log[k]},  {31'd0, q});
    check({tag, "_sel"},  {31'd0, sel_log[k]},  {31'd0, s});
    check({tag, "_din"},  {24'd0, din_log[k]},  {24'd0, din});
  endtask

  initial begin
    int a;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_sel = 1'b0; cmd_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_err", {31'd0, rsp_err}, 0);
    check("rst_rsp_data", {24'd0, rsp_data}, 0);
    check("rst_strobes", {29'd0, push, pop, stack_select}, 0);
    check("rst_data_in", {24'd0, data_in}, 0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", {31'd0, cmd_ready}, 1);

    send(3'd5, 1'b0, 8'h00, 1, a); wait_done();

    send(3'd1, 1'b0, 8'hA5, 1, a); wait_done();
    chk_strb("push_a5", a + 1, 1'b1, 1'b0, 1'b0, 8'hA5);
    send(3'd2, 1'b0, 8'h00, 1, a); wait_done();
    chk_strb("pop_a5", a + 1, 1'b0, 1'b1, 1'b0, 8'h00);

    send(3'd2, 1'b1, 8'h00, 1, a); wait_done();
    chk_strb("pop_empty", a + 1, 1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < CAP; i++) begin send(3'd1, 1'b0, 8'(8'h10 * (i + 1)), 1, a); wait_done(); end
    send(3'd1, 1'b0, 8'h50, 1, a); wait_done();
    chk_strb("push_full", a + 1, 1'b0, 1'b0, 1'b0, 8'h00);
    send(3'd5, 1'b0, 8'h00, 1, a); wait_done();
    send(3'd4, 1'b0, 8'h00, 1, a); wait_done();
    chk_strb("dup_full", a + 1, 1'b0, 1'b0, 1'b0, 8'h00);
    send(3'd3, 1'b0, 8'h00, 1, a); wait_done();
    for (int i = 0; i < CAP - 1; i++) begin send(3'd2, 1'b0, 8'h00, 1, a); wait_done(); end
    send(3'd2, 1'b1, 8'h00, 1, a); wait_done();

    send(3'd1, 1'b0, 8'h3C, 1, a); wait_done();
    send(3'd3, 1'b0, 8'h00, 1, a); wait_done();
    chk_strb("move_pop", a + 1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk_strb("move_gap", a + 2, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_strb("move_push", a + 3, 1'b1, 1'b0, 1'b1, 8'h3C);
    send(3'd2, 1'b1, 8'h00, 1, a); wait_done();
    send(3'd5, 1'b0, 8'h00, 1, a); wait_done();

    send(3'd1, 1'b1, 8'h77, 1, a); wait_done();
    send(3'd4, 1'b1, 8'h00, 1, a); wait_done();
    chk_strb("dup_pop", a + 1, 1'b0, 1'b1, 1'b1, 8'h00);
    chk_strb("dup_push1", a + 3, 1'b1, 1'b0, 1'b1, 8'h77);
    chk_strb("dup_push2", a + 4, 1'b1, 1'b0, 1'b1, 8'h77);
    send(3'd2, 1'b1, 8'h00, 1, a); wait_done();
    send(3'd2, 1'b1, 8'h00, 1, a); wait_done();

    send(3'd7, 1'b0, 8'h99, 1, a); wait_done();
    send(3'd6, 1'b1, 8'h98, 1, a); wait_done();
    send(3'd0, 1'b0, 8'h12, 1, a); wait_done();

    for (int i = 0; i < 12; i++) send(3'($urandom_range(0, 5)), 1'($urandom), 8'($urandom), 1, a);
    wait_done();

    while (ref0.size() != 0 || ref1.size() != 0) begin
      send(3'd2, ref0.size() != 0 ? 1'b0 : 1'b1, 8'h00, 1, a); wait_done();
    end

    send(3'd1, 1'b0, 8'h11, 1, a); wait_done();
    send(3'd3, 1'b0, 8'h00, 0, a);
    @(posedge clk); #1;
    rst_n = 1'b0;
    ref0.delete(); ref1.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_push", {31'd0, push}, 0);
      check("abort_rsp", {31'd0, rsp_valid}, 0);
    end
    rst_n = 1'b1;
    #1;
    check("abort_ready", {31'd0, cmd_ready}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_push", {31'd0, push}, 0);
      check("post_rsp", {31'd0, rsp_valid}, 0);
    end
    send(3'd5, 1'b0, 8'h00, 1, a); wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d want 0", cyc);
    $fatal(1, "timeout");
  end

endmodule
